// File: rtl/logic_analyzer_pkg.sv
// logic_analyzer_pkg
//   Shared definitions for the logic-analyzer capture/readback path.
//   LA_ADDR_W / LA_DATA_W : default BRAM address and sample widths.
//   rd_state_e            : host-reader FSM states of bram_port_arbiter.
package logic_analyzer_pkg;

  localparam int LA_ADDR_W = 18;
  localparam int LA_DATA_W = 8;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_WAIT  = 2'd1,
    RD_ISSUE = 2'd2,
    RD_LATCH = 2'd3
  } rd_state_e;

endpackage

// File: rtl/bram_skid_reg.sv
// bram_skid_reg
//   One-entry register slice holding a capture write that could not reach
//   the BRAM port in its own cycle.
//   clk, reset       : clock, synchronous active-high reset (drops the entry)
//   i_load           : capture i_we/i_addr/i_data, mark valid (wins over drain)
//   i_drain          : entry was written to BRAM this cycle, mark empty
//   o_valid/o_we/o_addr/o_data : held entry
module bram_skid_reg #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // A load in the same cycle as a drain is a refill: the old entry leaves
  // on the BRAM port while the new write takes its place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one BRAM port between the capture engine (priority, zero-latency
//   pass-through) and a host single-sample reader (IDLE/WAIT/ISSUE/LATCH).
//   Optional starvation guard: define BRAM_ARB_STARVE_GUARD_EN. The reader is
//   then forced onto the port after STARVE_LIMIT blocked cycles and the
//   displaced capture write is parked in a one-entry skid (bram_skid_reg).
//   Ports:
//     clk, reset                         : clock, sync active-high reset
//     cap_en/cap_we/cap_addr/cap_data    : capture write request
//     rd_req/rd_base/rd_addr             : host read, phys = base + addr (wraps)
//     rd_ack/rd_data/rd_busy             : read completion pulse, data, busy
//     bram_en/bram_we/bram_addr/bram_din : shared BRAM port
//     bram_dout                          : BRAM read data (1-cycle latency)
//     cap_overflow                       : sticky lost-capture-write flag
module bram_port_arbiter
  import logic_analyzer_pkg::*;
#(
  parameter int ADDR_W       = LA_ADDR_W,
  parameter int DATA_W       = LA_DATA_W,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              cap_overflow
);

  rd_state_e         r_state, w_state_nxt;
  logic              r_rd_ack;
  logic              r_rd_busy;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_phys;

  logic w_accept;
  logic w_port_busy;
  logic w_rd_issue;   // reader owns the BRAM port this cycle
  logic w_wait_go;    // WAIT may advance to ISSUE

  // Busy stays set through the ack cycle, so a request there is ignored too.
  assign w_accept = (r_state == RD_IDLE) && rd_req && !r_rd_busy;

`ifdef BRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_force;
  logic              r_overflow;
  logic              w_skid_valid;
  logic              w_skid_we;
  logic [ADDR_W-1:0] w_skid_addr;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_load;
  logic              w_skid_drain;
  logic              w_cap_drop;
  logic              w_starved;

  assign w_port_busy  = cap_en | w_skid_valid;
  assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1));
  assign w_wait_go    = !w_port_busy || w_starved;
  assign w_rd_issue   = (r_state == RD_ISSUE) && (!w_port_busy || r_force);
  assign w_skid_drain = w_skid_valid && !w_rd_issue;
  // Park the capture write when the reader took the port (empty skid only),
  // or refill behind a draining entry so older data reaches BRAM first.
  assign w_skid_load  = cap_en && (w_rd_issue ? !w_skid_valid : w_skid_valid);
  assign w_cap_drop   = cap_en && w_rd_issue && w_skid_valid;

  bram_skid_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_we    (cap_we),
    .i_addr  (cap_addr),
    .i_data  (cap_data),
    .o_valid (w_skid_valid),
    .o_we    (w_skid_we),
    .o_addr  (w_skid_addr),
    .o_data  (w_skid_data)
  );

  // Counts reader cycles lost to capture traffic, in WAIT and while ISSUE
  // yields; at the limit r_force makes the next ISSUE cycle unconditional.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_force      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_cap_drop)
        r_overflow <= 1'b1;
      if (w_rd_issue) begin
        r_starve_cnt <= '0;
        r_force      <= 1'b0;
      end else if ((r_state == RD_WAIT || r_state == RD_ISSUE) &&
                   w_port_busy && !r_force) begin
        if (w_starved) begin
          r_force      <= 1'b1;
          r_starve_cnt <= '0;
        end else begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

  assign cap_overflow = r_overflow;
`else
  assign w_port_busy  = cap_en;
  assign w_wait_go    = !w_port_busy;
  // A capture write landing in the ISSUE cycle still wins; the read retries.
  assign w_rd_issue   = (r_state == RD_ISSUE) && !w_port_busy;
  assign cap_overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= RD_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE:  if (w_accept)   w_state_nxt = RD_WAIT;
      RD_WAIT:  if (w_wait_go)  w_state_nxt = RD_ISSUE;
      RD_ISSUE: if (w_rd_issue) w_state_nxt = RD_LATCH;
      RD_LATCH: w_state_nxt = RD_IDLE;
      default:  w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ack  <= 1'b0;
      r_rd_busy <= 1'b0;
      r_rd_data <= '0;
      r_phys    <= '0;
    end else begin
      r_rd_ack <= (r_state == RD_LATCH);
      if (r_state == RD_LATCH)
        r_rd_data <= bram_dout;
      if (w_accept) begin
        r_phys    <= rd_base + rd_addr;   // carry out dropped: ring wrap
        r_rd_busy <= 1'b1;
      end else if (r_rd_ack) begin
        r_rd_busy <= 1'b0;
      end
    end
  end

  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

  // Port mux: reader issue, then skid drain, then live capture write.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (!reset) begin
      if (w_rd_issue) begin
        bram_en   = 1'b1;
        bram_addr = r_phys;
      end
`ifdef BRAM_ARB_STARVE_GUARD_EN
      else if (w_skid_valid) begin
        bram_en   = 1'b1;
        bram_we   = w_skid_we;
        bram_addr = w_skid_addr;
        bram_din  = w_skid_data;
      end
`endif
      else if (cap_en) begin
        bram_en   = 1'b1;
        bram_we   = cap_we;
        bram_addr = cap_addr;
        bram_din  = cap_data;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;
  localparam int AW  = 18;
  localparam int DW  = 8;
  localparam int LIM = 16;
  localparam int MSZ = 1 << AW;
`ifdef BRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cap_en, cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          rd_req;
  logic [AW-1:0] rd_base, rd_addr;
  logic          rd_ack, rd_busy;
  logic [DW-1:0] rd_data;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          cap_overflow;

  int n_checks = 0;
  int n_errs   = 0;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cap_en(cap_en), .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .rd_req(rd_req), .rd_base(rd_base), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_busy(rd_busy),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .cap_overflow(cap_overflow)
  );

  always #5 clk = ~clk;

  // BRAM environment: 1-cycle read latency.
  logic [DW-1:0] mem [MSZ];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout      <= mem[bram_addr];
    end
  end

  function automatic logic [DW-1:0] init_val(input int i);
    init_val = DW'(i * 7 + 3);
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic we; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  logic [DW-1:0] emem [MSZ];     // what BRAM must contain
  wr_t           skq[$];         // parked capture writes (at most one)
  bit            m_busy, m_ack, m_ovf, m_force;
  int            m_ph;           // 0 no read, 1 needs a free cycle, 2 may take port, 3 data returning
  int            m_blk;          // cycles the pending read lost to captures
  logic [AW-1:0] m_phys;
  logic [DW-1:0] m_data, m_rdval;

  always @(negedge clk) begin : cmp
    bit            pbusy, iss, drn, n_ack;
    int            ph0;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    pbusy  = cap_en || (skq.size() > 0);
    iss    = (m_ph == 2) && (!pbusy || m_force);
    drn    = (skq.size() > 0) && !iss;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
    if (!reset) begin
      if (iss) begin e_en = 1'b1; e_addr = m_phys; end
      else if (drn) begin e_en = 1'b1; e_we = skq[0].we; e_addr = skq[0].a; e_din = skq[0].d; end
      else if (cap_en) begin e_en = 1'b1; e_we = cap_we; e_addr = cap_addr; e_din = cap_data; end
    end
    n_checks++;
    if (bram_en !== e_en || bram_we !== e_we ||
        (e_en && (bram_addr !== e_addr || bram_din !== e_din)) ||
        rd_ack !== m_ack || rd_busy !== m_busy || rd_data !== m_data ||
        cap_overflow !== m_ovf) begin
      n_errs++;
      $display("FAIL cycle_model t=%0t: en/we/addr/din %b%b %h %h want %b%b %h %h ack %b want %b busy %b want %b data %h want %h ovf %b want %b",
               $time, bram_en, bram_we, bram_addr, bram_din, e_en, e_we, e_addr, e_din,
               rd_ack, m_ack, rd_busy, m_busy, rd_data, m_data, cap_overflow, m_ovf);
    end
    if (reset) begin
      m_busy = 0; m_ack = 0; m_ovf = 0; m_force = 0; m_ph = 0; m_blk = 0;
      m_data = '0; skq.delete();
    end else begin
      if (e_en && e_we) emem[e_addr] = e_din;
      if (iss) m_rdval = emem[m_phys];
      if (GUARD) begin
        if (drn) void'(skq.pop_front());
        if (cap_en) begin
          if (iss) begin
            if (skq.size() == 0) skq.push_back('{cap_we, cap_addr, cap_data});
            else m_ovf = 1;
          end else if (drn) begin
            skq.push_back('{cap_we, cap_addr, cap_data});
          end
        end
      end
      ph0   = m_ph;
      n_ack = (ph0 == 3);
      if (ph0 == 3) m_data = m_rdval;
      if (ph0 == 0 && rd_req && !m_busy) begin
        m_busy = 1; m_phys = rd_base + rd_addr; m_ph = 1;
      end else if (m_ack) begin
        m_busy = 0;
      end
      case (ph0)
        1: if (!pbusy) m_ph = 2;
           else if (GUARD) begin
             m_blk++;
             if (m_blk >= LIM) begin m_ph = 2; m_force = 1; end
           end
        2: if (iss) begin m_ph = 3; m_force = 0; m_blk = 0; end
           else if (GUARD) begin
             m_blk++;
             if (m_blk >= LIM) m_force = 1;
           end
        3: m_ph = 0;
        default: ;
      endcase
      m_ack = n_ack;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    cap_en = 0; cap_we = 0; cap_addr = '0; cap_data = '0; rd_req = 0; reset = 0;
  endtask

  // One read; optional one-cycle capture write at offset cap_k, reset at
  // offset rst_k, re-request during busy. Offsets count cycles after acceptance.
  task automatic run_read(input logic [AW-1:0] base, input logic [AW-1:0] off,
                          input int cap_k, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                          input int rst_k, input bit rereq,
                          output int lat, output int nack, output int iss_k,
                          output logic [AW-1:0] iss_addr);
    rd_base = base; rd_addr = off; rd_req = 1;
    step();
    rd_req = 0; lat = -1; nack = 0; iss_k = -1; iss_addr = '0;
    for (int k = 0; k < 40; k++) begin
      cap_en = (k == cap_k); cap_we = 1; cap_addr = ca; cap_data = cd;
      reset  = (k == rst_k);
      rd_req = rereq && (k == 1 || k == 2);
      @(negedge clk);
      if (k == cap_k) begin
        chk("cap_pass_we", bram_we, 1);
        chk("cap_pass_addr", bram_addr, ca);
        chk("cap_pass_din", bram_din, cd);
      end
      if (rst_k >= 0 && k == rst_k + 1) chk("busy_after_reset", rd_busy, 0);
      if (iss_k < 0 && bram_en && !bram_we) begin iss_k = k; iss_addr = bram_addr; end
      if (rd_ack) begin nack++; if (lat < 0) lat = k; end
      step();
    end
    idle_in();
  endtask

  task automatic read_value(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    int lat, nack, ik; logic [AW-1:0] ia;
    run_read('0, a, -1, '0, '0, -1, 1'b0, lat, nack, ik, ia);
    chk(nm, rd_data, exp);
  endtask

  initial begin
    int lat, nack, ik, burst;
    logic [AW-1:0] ia, tgt;
    for (int i = 0; i < MSZ; i++) begin mem[i] = init_val(i); emem[i] = init_val(i); end
    bram_dout = '0;
    m_busy = 0; m_ack = 0; m_ovf = 0; m_force = 0; m_ph = 0; m_blk = 0;
    m_phys = '0; m_data = '0; m_rdval = '0;
    idle_in(); rd_base = '0; rd_addr = '0;
    reset = 1; cap_en = 1; cap_we = 1; cap_addr = 18'h5; cap_data = 8'hEE;
    step(); step();
    @(negedge clk);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", cap_overflow, 0);
    step();
    idle_in(); step();

    // wrap-around address, minimum latency
    run_read(18'h3FFF0, 18'h20, -1, '0, '0, -1, 1'b0, lat, nack, ik, ia);
    chk("wrap_issue_addr", ia, 18'h00010);
    chk("wrap_issue_cycle", ik, 1);
    chk("wrap_latency", lat, 3);
    chk("wrap_data", rd_data, 8'h73);

    // capture write in the ISSUE cycle to the read address: capture first
    run_read('0, 18'h30, 1, 18'h30, 8'hC3, -1, 1'b0, lat, nack, ik, ia);
    chk("contend_issue_cycle", ik, 2);
    chk("contend_latency", lat, 4);
    chk("contend_data", rd_data, 8'hC3);

    // capture write in the WAIT cycle
    run_read('0, 18'h25, 0, 18'h200, 8'h99, -1, 1'b0, lat, nack, ik, ia);
    chk("wait_contend_latency", lat, 4);
    chk("wait_contend_data", rd_data, 8'h06);
    read_value(18'h200, 8'h99, "cap_write_landed");

    // re-request while busy
    run_read('0, 18'h41, -1, '0, '0, -1, 1'b1, lat, nack, ik, ia);
    chk("rereq_acks", nack, 1);
    chk("rereq_latency", lat, 3);
    chk("rereq_data", rd_data, 8'hCA);

    // reset during LATCH
    run_read('0, 18'h41, -1, '0, '0, 2, 1'b0, lat, nack, ik, ia);
    chk("rst_mid_acks", nack, 0);
    run_read('0, 18'h7, -1, '0, '0, -1, 1'b0, lat, nack, ik, ia);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_data", rd_data, 8'h34);

`ifdef BRAM_ARB_STARVE_GUARD_EN
    // continuous capture for 40 cycles with a pending read
    rd_base = '0; rd_addr = 18'h2A0; rd_req = 1;
    cap_en = 1; cap_we = 1; cap_addr = 18'h1000; cap_data = 8'h40;
    step();
    rd_req = 0; lat = -1; ik = -1;
    for (int k = 0; k < 60; k++) begin
      cap_en = (k + 1 < 40); cap_addr = 18'h1000 + AW'(k + 1); cap_data = DW'(8'h40 + k + 1);
      @(negedge clk);
      if (ik < 0 && bram_en && !bram_we) ik = k;
      if (k == 17) begin
        chk("skid_drain_we", bram_we, 1);
        chk("skid_drain_addr", bram_addr, 18'h1011);
        chk("skid_drain_din", bram_din, 8'h51);
      end
      if (rd_ack && lat < 0) lat = k;
      step();
    end
    idle_in();
    chk("force_issue_cycle", ik, 16);
    chk("force_latency", lat, 18);
    chk("force_data", rd_data, 8'h63);
    chk("force_no_ovf", cap_overflow, 0);
    read_value(18'h1011, 8'h51, "stalled_write_intact");
    read_value(18'h1027, 8'h67, "last_write_intact");

    // second forced issue with the skid still full -> overflow
    rd_base = '0; rd_addr = 18'h300; rd_req = 1;
    cap_en = 1; cap_we = 1; cap_addr = 18'h1100; cap_data = 8'h00;
    step();
    for (int k = 0; k < 80; k++) begin
      rd_req = (k < 22); cap_en = (k < 70);
      cap_addr = 18'h1100 + AW'(k + 1); cap_data = DW'(k + 1);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("ovf_set", cap_overflow, 1);
    repeat (5) step();
    @(negedge clk);
    chk("ovf_sticky", cap_overflow, 1);
    step();
    reset = 1; step(); step(); reset = 0;
    @(negedge clk);
    chk("ovf_cleared", cap_overflow, 0);
    step();
`endif

    // randomized traffic against the model
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(399) == 0);
      if (burst > 0) begin cap_en = 1; burst--; end
      else begin
        cap_en = ($urandom_range(3) == 0);
        if ($urandom_range(149) == 0) burst = $urandom_range(35, 20);
      end
      cap_we   = ($urandom_range(7) != 0);
      cap_addr = AW'($urandom_range(63));
      cap_data = DW'($urandom);
      rd_req   = ($urandom_range(2) == 0);
      tgt      = AW'($urandom_range(63));
      rd_base  = AW'($urandom);
      rd_addr  = tgt - rd_base;
      step();
    end
    idle_in();
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
